// File: rtl/tick_divider_pkg.sv
// ============================================================================
// tick_divider_pkg : shared defaults, divisor type and channel-select width
// Revision: 1.0
// ============================================================================
`default_nettype none

package tick_divider_pkg;

   localparam int TD_CNT_W       = 16;
   localparam int TD_DEFAULT_DIV = 624;

   typedef logic [TD_CNT_W-1:0] div_t;

   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tick_divider_if.sv
// ============================================================================
// tick_divider_if : control/status bundle of the multi-channel tick divider
// Revision: 1.0
// ============================================================================
`default_nettype none

interface tick_divider_if
   import tick_divider_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = TD_CNT_W
);
   localparam int CH_W = ch_width(NUM_CH);

   logic [NUM_CH-1:0] i_en;
   logic              i_sync;
   logic              i_wr_en;
   logic [CH_W-1:0]   i_wr_ch;
   logic [CNT_W-1:0]  i_wr_div;
   logic [NUM_CH-1:0] o_tick;
   logic [NUM_CH-1:0] o_clk;
   logic [NUM_CH-1:0] o_pending;

   modport master (
      output i_en, i_sync, i_wr_en, i_wr_ch, i_wr_div,
      input  o_tick, o_clk, o_pending
   );

   modport slave (
      input  i_en, i_sync, i_wr_en, i_wr_ch, i_wr_div,
      output o_tick, o_clk, o_pending
   );

endinterface

`default_nettype wire

// File: rtl/tick_divider_channel.sv
// ============================================================================
// tick_channel : one divider slice (counter, active/shadow divisor, pending)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tick_channel
   import tick_divider_pkg::*;
#(
   parameter int CNT_W       = TD_CNT_W,
   parameter int DEFAULT_DIV = TD_DEFAULT_DIV
) (
   input  wire logic             i_clk,
   input  wire logic             i_rst,
   input  wire logic             en_i,
   input  wire logic             sync_i,
   input  wire logic             wr_i,
   input  wire logic [CNT_W-1:0] wr_div_i,
   output logic                  tick_o,
   output logic                  clk_o,
   output logic                  pending_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] act_q, act_d;
   logic [CNT_W-1:0] shd_q, shd_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             clk_q, clk_d;

   always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      clk_d  = clk_q;

      if (sync_i || !en_i) begin
         cnt_d = '0;
         clk_d = 1'b0;
         if (pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
         end
      end else if (cnt_q == act_q) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         clk_d  = ~clk_q;
         // A write landing on the wrap itself is held for the next wrap
         if (pend_q && !wr_i) begin
            act_d  = shd_q;
            pend_d = 1'b0;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      if (wr_i) begin
         shd_d  = wr_div_i;
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q  <= '0;
         act_q  <= CNT_W'(DEFAULT_DIV);
         shd_q  <= CNT_W'(DEFAULT_DIV);
         pend_q <= 1'b0;
         tick_q <= 1'b0;
         clk_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         shd_q  <= shd_d;
         pend_q <= pend_d;
         tick_q <= tick_d;
         clk_q  <= clk_d;
      end
   end

   assign tick_o    = tick_q;
   assign clk_o     = clk_q;
   assign pending_o = pend_q;

endmodule

`default_nettype wire

// File: rtl/tick_divider.sv
// ============================================================================
// tick_divider : NUM_CH programmable tick/square-clock dividers with shadowed
//                divisors, per-channel enable and global phase align
// Revision: 1.0
// ============================================================================
`default_nettype none

module tick_divider
   import tick_divider_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = TD_CNT_W,
   parameter int DEFAULT_DIV = TD_DEFAULT_DIV
) (
   input  wire logic     i_clk,
   input  wire logic     i_rst,
   tick_divider_if.slave bus
);

   localparam int CH_W = ch_width(NUM_CH);

   logic [NUM_CH-1:0] w_tick;
   logic [NUM_CH-1:0] w_clk;
   logic [NUM_CH-1:0] w_pending;

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         // Select values at or beyond NUM_CH match no slice and are dropped
         logic w_wr_hit;
         assign w_wr_hit = bus.i_wr_en && (bus.i_wr_ch == CH_W'(c));

         tick_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
         ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .en_i      (bus.i_en[c]),
            .sync_i    (bus.i_sync),
            .wr_i      (w_wr_hit),
            .wr_div_i  (bus.i_wr_div),
            .tick_o    (w_tick[c]),
            .clk_o     (w_clk[c]),
            .pending_o (w_pending[c])
         );
      end
   endgenerate

   assign bus.o_tick    = w_tick;
   assign bus.o_clk     = w_clk;
   assign bus.o_pending = w_pending;

endmodule

`default_nettype wire

// File: tb/tb_tick_divider.sv
// ============================================================================
// tb_tick_divider : directed timeline plus random traffic against a
//                   period-arithmetic reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tick_divider;

   localparam int NCH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tick_divider_if #(.NUM_CH(NCH), .CNT_W(16)) bus ();
   tick_divider_if #(.NUM_CH(3),   .CNT_W(16)) bus2 ();

   tick_divider #(.NUM_CH(NCH), .CNT_W(16), .DEFAULT_DIV(624)) dut (
      .i_clk (clk), .i_rst (rst), .bus (bus.slave)
   );

   tick_divider #(.NUM_CH(3), .CNT_W(16), .DEFAULT_DIV(5)) dut3 (
      .i_clk (clk), .i_rst (rst), .bus (bus2.slave)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Model: per channel, cycles elapsed in the current constant-divisor
   // segment and the square level at the segment start.
   int m_k[NCH], m_act[NCH], m_shd[NCH];
   bit m_pend[NCH], m_base[NCH], m_tick[NCH], m_clk[NCH];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_k[c] = 0; m_act[c] = 624; m_shd[c] = 624;
         m_pend[c] = 0; m_base[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
      end
   endtask

   task automatic model_update();
      for (int c = 0; c < NCH; c++) begin
         bit wr;
         wr = bus.i_wr_en && (int'(bus.i_wr_ch) == c);
         if (bus.i_sync || !bus.i_en[c]) begin
            m_k[c] = 0; m_base[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
            if (m_pend[c]) begin m_act[c] = m_shd[c]; m_pend[c] = 0; end
         end else begin
            m_k[c]++;
            m_tick[c] = (m_k[c] % (m_act[c] + 1)) == 0;
            m_clk[c]  = m_base[c] ^ (((m_k[c] / (m_act[c] + 1)) % 2) == 1);
            if (m_tick[c] && m_pend[c] && !wr) begin
               m_act[c] = m_shd[c]; m_pend[c] = 0;
               m_base[c] = m_clk[c]; m_k[c] = 0;
            end
         end
         if (wr) begin m_shd[c] = int'(bus.i_wr_div); m_pend[c] = 1; end
      end
   endtask

   task automatic compare();
      logic [NCH-1:0] et, ec, ep;
      for (int c = 0; c < NCH; c++) begin
         et[c] = m_tick[c]; ec[c] = m_clk[c]; ep[c] = m_pend[c];
      end
      check("model_tick",    int'(bus.o_tick),    int'(et));
      check("model_clk",     int'(bus.o_clk),     int'(ec));
      check("model_pending", int'(bus.o_pending), int'(ep));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      cyc++;
      compare();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input int ch, input int d);
      bus.i_wr_en = 1'b1; bus.i_wr_ch = 2'(ch); bus.i_wr_div = 16'(d);
      step();
      bus.i_wr_en = 1'b0;
   endtask

   initial begin
      bus.i_en = '0; bus.i_sync = 1'b0; bus.i_wr_en = 1'b0;
      bus.i_wr_ch = '0; bus.i_wr_div = '0;
      bus2.i_en = '0; bus2.i_sync = 1'b0; bus2.i_wr_en = 1'b0;
      bus2.i_wr_ch = '0; bus2.i_wr_div = '0;
      model_reset();
      #12;
      check("reset_tick",    int'(bus.o_tick),    0);
      check("reset_clk",     int'(bus.o_clk),     0);
      check("reset_pending", int'(bus.o_pending), 0);
      bus.i_en = '1;
      #8 rst = 1'b0;

      // Out-of-range write select on a 3-channel instance
      bus2.i_wr_en = 1'b1; bus2.i_wr_ch = 2'd3; bus2.i_wr_div = 16'd2;
      step();
      check("oob_write_ignored", int'(bus2.o_pending), 0);
      bus2.i_wr_ch = 2'd2;
      step();
      check("inrange_write_pend", int'(bus2.o_pending), 3'b100);
      bus2.i_wr_en = 1'b0;
      run(98);

      wr(1, 3);
      check("wr1_pending", int'(bus.o_pending), 4'b0010);
      wr(2, 0);
      check("wr2_pending", int'(bus.o_pending), 4'b0110);
      run(522);
      check("no_tick_624", int'(bus.o_tick), 0);
      step();
      check("first_tick_625", int'(bus.o_tick), 4'hF);
      check("clk_rise_625",   int'(bus.o_clk),  4'hF);
      check("pend_clear_625", int'(bus.o_pending), 0);
      run(4);
      check("ch1_d3_ch2_d0", int'(bus.o_tick), 4'b0110);

      run(620);
      wr(0, 9);
      check("wrap_write_tick", int'(bus.o_tick[0]), 1);
      check("wrap_write_pend", int'(bus.o_pending), 4'b0001);
      check("clk_fall_1250",   int'(bus.o_clk[0]), 0);
      run(625);
      check("old_div_wrap", int'(bus.o_tick[0]), 1);
      check("applied_pend", int'(bus.o_pending[0]), 0);
      run(10);
      check("new_period10", int'(bus.o_tick[0]), 1);

      wr(3, 3);
      bus.i_sync = 1'b1;
      step();
      bus.i_sync = 1'b0;
      check("sync_clk",  int'(bus.o_clk),     0);
      check("sync_pend", int'(bus.o_pending), 0);
      run(4);
      check("sync_aligned", int'(bus.o_tick), 4'b1110);

      bus.i_en = 4'b0111;
      step();
      wr(3, 7);
      check("idle_pend_set", int'(bus.o_pending), 4'b1000);
      step();
      check("idle_pend_apply", int'(bus.o_pending[3]), 0);
      check("idle_clk_low",    int'(bus.o_clk[3]),     0);
      bus.i_en = '1;
      run(7);
      check("reen_no_tick", int'(bus.o_tick[3]), 0);
      step();
      check("reen_tick8", int'(bus.o_tick[3]), 1);

      wr(1, 11);
      run(5);
      rst = 1'b1;
      #2;
      check("async_rst_tick", int'(bus.o_tick),    0);
      check("async_rst_clk",  int'(bus.o_clk),     0);
      check("async_rst_pend", int'(bus.o_pending), 0);
      model_reset();
      #2 rst = 1'b0;
      run(624);
      check("rst_no_tick_624", int'(bus.o_tick), 0);
      step();
      check("rst_tick_625", int'(bus.o_tick), 4'hF);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 31) == 0)
            bus.i_en[$urandom_range(0, NCH-1)] ^= 1'b1;
         bus.i_sync   = ($urandom_range(0, 99) == 0);
         bus.i_wr_en  = ($urandom_range(0, 5) == 0);
         bus.i_wr_ch  = 2'($urandom_range(0, NCH-1));
         bus.i_wr_div = 16'($urandom_range(0, 12));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
